// File: rtl/mprj_pad_cfg_seq.sv
// Configuration sequencer for user GPIO pads: shadow/live config words with a
// glitch-safe hold/update/settle apply sequence and fixed-safe analog pads.
module mprj_pad_cfg_seq #(
    parameter int unsigned         NUM_PADS    = 38,
    parameter logic [NUM_PADS-1:0] ANALOG_MASK = '0,
    parameter int unsigned         HOLD_CYCLES = 4,
    parameter logic [11:0]         RESET_CFG   = 12'h403
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     porb,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [5:0]               cfg_addr,
    input  logic [11:0]              cfg_data,
    output logic                     cfg_err,
    input  logic                     apply_req,
    output logic                     apply_busy,
    output logic                     apply_done,
    output logic [12*NUM_PADS-1:0]   pad_cfg,
    output logic [NUM_PADS-1:0]      pad_hold_n,
    output logic [NUM_PADS-1:0]      pad_enh
);

    localparam logic [11:0] ANALOG_CFG = 12'h010;
    localparam logic [63:0] MASK64     = 64'(ANALOG_MASK);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PEND, FREEZE, UPDATE, SETTLE, DONE} state_t;

    state_t              state, state_d;
    logic [7:0]          cnt, cnt_d;
    logic                porb_m, porb_s;
    logic [NUM_PADS-1:0] dirty, frozen, frozen_d, wr_mask, pending;
    logic [11:0]         shadow [NUM_PADS];
    logic [11:0]         live   [NUM_PADS];
    logic                wr_acc, wr_bad, upd, hold_phase;

    always_comb begin
        wr_acc  = cfg_valid & cfg_ready;
        wr_bad  = ({1'b0, cfg_addr} >= 7'(NUM_PADS)) || MASK64[cfg_addr];
        wr_mask = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++)
            wr_mask[i] = wr_acc && !wr_bad && (cfg_addr == 6'(i));
        // a write in the same cycle as the request joins this apply
        pending    = dirty | wr_mask;
        hold_phase = (state == FREEZE) || (state == UPDATE) || (state == SETTLE);
    end

    always_comb begin
        state_d  = state;
        cnt_d    = '0;
        frozen_d = frozen;
        case (state)
            IDLE: if (apply_req) begin
                if (pending == '0) state_d = DONE;
                else if (porb_s) begin
                    state_d  = FREEZE;
                    frozen_d = pending;
                end else state_d = PEND;
            end
            PEND: if (porb_s) begin
                if (pending == '0) state_d = DONE;
                else begin
                    state_d  = FREEZE;
                    frozen_d = pending;
                end
            end
            FREEZE: if (cnt == HOLD_LAST) state_d = UPDATE;
                    else cnt_d = cnt + 8'd1;
            UPDATE: state_d = SETTLE;
            SETTLE: if (cnt == HOLD_LAST) state_d = DONE;
                    else cnt_d = cnt + 8'd1;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            cnt        <= '0;
            frozen     <= '0;
            porb_m     <= 1'b0;
            porb_s     <= 1'b0;
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
            apply_busy <= 1'b0;
            apply_done <= 1'b0;
            pad_hold_n <= '1;
            upd        <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            frozen     <= frozen_d;
            porb_m     <= porb;
            porb_s     <= porb_m;
            cfg_ready  <= (state_d == IDLE) || (state_d == PEND);
            cfg_err    <= wr_acc & wr_bad;
            apply_busy <= (state_d != IDLE);
            apply_done <= (state == DONE);
            pad_hold_n <= ~(frozen & {NUM_PADS{hold_phase}});
            upd        <= (state == UPDATE);
        end
    end

    // Outputs are registered one cycle behind the state, so the live copy is
    // written on the edge after UPDATE to stay aligned with the hold outputs.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            dirty <= '0;
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
                shadow[i] <= ANALOG_MASK[i] ? ANALOG_CFG : RESET_CFG;
                live[i]   <= ANALOG_MASK[i] ? ANALOG_CFG : RESET_CFG;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
                if (ANALOG_MASK[i]) begin
                    live[i] <= ANALOG_CFG;
                end else if (wr_mask[i]) begin
                    shadow[i] <= cfg_data;
                    dirty[i]  <= 1'b1;
                end else if (upd && dirty[i]) begin
                    live[i]  <= shadow[i];
                    dirty[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pad_cfg = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++)
            pad_cfg[12*i +: 12] = live[i];
    end

    assign pad_enh = {NUM_PADS{porb_s}} & ~ANALOG_MASK;

endmodule

// File: tb/tb_mprj_pad_cfg_seq.sv
// Self-checking bench for mprj_pad_cfg_seq: dropped-write table, apply timing,
// pending apply, collisions and asynchronous reset mid-sequence.
module tb_mprj_pad_cfg_seq;

    localparam int unsigned   NP = 38;
    localparam logic [NP-1:0] AM = 38'h3F_0000_0000;
    localparam int unsigned   HC = 4;
    localparam int            PW = 12 * NP;

    logic            clock, resetb, porb, cfg_valid, cfg_ready, cfg_err;
    logic [5:0]      cfg_addr;
    logic [11:0]     cfg_data;
    logic            apply_req, apply_busy, apply_done;
    logic [PW-1:0]   pad_cfg;
    logic [NP-1:0]   pad_hold_n, pad_enh;

    mprj_pad_cfg_seq #(
        .NUM_PADS(NP), .ANALOG_MASK(AM), .HOLD_CYCLES(HC), .RESET_CFG(12'h403)
    ) dut (
        .clock(clock), .resetb(resetb), .porb(porb),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err),
        .apply_req(apply_req), .apply_busy(apply_busy), .apply_done(apply_done),
        .pad_cfg(pad_cfg), .pad_hold_n(pad_hold_n), .pad_enh(pad_enh)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_pass = 0, n_total = 0;

    typedef struct { string name; logic [PW-1:0] val; } exp_t;
    exp_t sb[$];

    typedef struct { logic [5:0] addr; logic [11:0] data; logic err; } wr_vec_t;
    wr_vec_t vecs[6];

    logic [11:0]   model    [NP];
    logic [11:0]   shadow_m [NP];
    logic [NP-1:0] dirty_m;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input string name, input logic [PW-1:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [PW-1:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got %0h expected an entry", act);
        end else begin
            e = sb.pop_front();
            check(e.name, act, e.val);
        end
    endtask

    function automatic logic [PW-1:0] model_vec();
        logic [PW-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[12*i +: 12] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            model[i]    = AM[i] ? 12'h010 : 12'h403;
            shadow_m[i] = model[i];
        end
        dirty_m = '0;
    endtask

    task automatic model_apply();
        for (int i = 0; i < NP; i++)
            if (dirty_m[i]) model[i] = shadow_m[i];
        dirty_m = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [11:0] data, input logic exp_err);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        push("cfg_err", PW'(exp_err));
        if (!exp_err) begin
            shadow_m[addr] = data;
            dirty_m[addr]  = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
        pop_check(PW'(cfg_err));
    endtask

    // Observes an apply for `cycles` clocks after the request edge; k counts edges after it.
    task automatic watch(input int pad, input int cycles, input int wr_k, input int req_k,
                         output int hold_cnt, output int hold_first, output int cfg_k,
                         output int done_cnt, output int done_k, output int other_bad,
                         output logic ready_seen);
        logic [NP-1:0] others;
        hold_cnt = 0; hold_first = -1; cfg_k = -1;
        done_cnt = 0; done_k = -1; other_bad = 0; ready_seen = 1'bx;
        for (int k = 1; k <= cycles; k++) begin
            tick();
            if (!pad_hold_n[pad]) begin
                hold_cnt++;
                if (hold_first < 0) hold_first = k;
            end
            others = pad_hold_n;
            others[pad] = 1'b1;
            if (others != '1) other_bad++;
            if (cfg_k < 0 && pad_cfg[12*pad +: 12] == shadow_m[pad]) cfg_k = k;
            if (apply_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == wr_k) begin
                cfg_valid = 1'b1; cfg_addr = 6'd8; cfg_data = 12'hFFF;
                ready_seen = cfg_ready;
            end else cfg_valid = 1'b0;
            apply_req = (k == req_k);
        end
        cfg_valid = 1'b0;
        apply_req = 1'b0;
    endtask

    int   hc, hf, ck, dc, dk, ob;
    logic rs;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6'd40, 12'h123, 1'b1};
        vecs[1] = '{6'd33, 12'h456, 1'b1};
        vecs[2] = '{6'd63, 12'h789, 1'b1};
        vecs[3] = '{6'd38, 12'hABC, 1'b1};
        vecs[4] = '{6'd32, 12'hDEF, 1'b1};
        vecs[5] = '{6'd37, 12'h111, 1'b1};

        resetb = 1'b0; porb = 1'b0; cfg_valid = 1'b0; cfg_addr = '0;
        cfg_data = '0; apply_req = 1'b0;
        model_reset();
        repeat (3) tick();
        check("ready_in_reset", PW'(cfg_ready), '0);
        check("hold_reset", PW'(pad_hold_n), PW'({NP{1'b1}}));
        check("enh_reset", PW'(pad_enh), '0);
        check("busy_reset", PW'(apply_busy), '0);
        check("done_reset", PW'(apply_done), '0);
        check("err_reset", PW'(cfg_err), '0);
        check("cfg_reset", pad_cfg, model_vec());

        @(negedge clock);
        resetb = 1'b1;
        tick();
        check("ready_after_reset", PW'(cfg_ready), PW'(1));
        porb = 1'b1;
        for (int k = 0; k < 3 && pad_enh != ~AM; k++) tick();
        check("enh_after_porb", PW'(pad_enh), PW'(38'h00_FFFF_FFFF));

        foreach (vecs[i]) do_write(vecs[i].addr, vecs[i].data, vecs[i].err);
        tick();
        check("err_clears", PW'(cfg_err), '0);
        check("cfg_after_drops", pad_cfg, model_vec());

        apply_req = 1'b1;
        tick();
        apply_req = 1'b0;
        check("nodirty_busy", PW'(apply_busy), PW'(1));
        tick();
        check("nodirty_done", PW'(apply_done), PW'(1));
        check("nodirty_hold", PW'(pad_hold_n), PW'({NP{1'b1}}));
        tick();
        check("nodirty_done_pulse", PW'({apply_done, apply_busy}), '0);

        do_write(6'd5, 12'h1C1, 1'b0);
        apply_req = 1'b1;
        tick();
        apply_req = 1'b0;
        watch(5, 14, -1, -1, hc, hf, ck, dc, dk, ob, rs);
        check("single_hold_cycles", PW'(hc), PW'(2*HC+1));
        check("single_hold_first", PW'(hf), PW'(1));
        check("single_cfg_cycle", PW'(ck), PW'(HC+2));
        check("single_done_count", PW'(dc), PW'(1));
        check("single_done_cycle", PW'(dk), PW'(2*HC+2));
        check("single_other_holds", PW'(ob), '0);
        model_apply();
        push("single_pad_cfg", model_vec());
        pop_check(pad_cfg);

        cfg_valid = 1'b1; cfg_addr = 6'd7; cfg_data = 12'h2A5; apply_req = 1'b1;
        shadow_m[7] = 12'h2A5; dirty_m[7] = 1'b1;
        push("coll_err", '0);
        tick();
        cfg_valid = 1'b0; apply_req = 1'b0;
        pop_check(PW'(cfg_err));
        watch(7, 16, 2, 6, hc, hf, ck, dc, dk, ob, rs);
        check("coll_ready_freeze", PW'(rs), '0);
        check("coll_hold_cycles", PW'(hc), PW'(2*HC+1));
        check("coll_done_count", PW'(dc), PW'(1));
        check("coll_idle_after", PW'(apply_busy), '0);
        model_apply();
        push("coll_pad_cfg", model_vec());
        pop_check(pad_cfg);

        porb = 1'b0;
        repeat (3) tick();
        check("enh_drop", PW'(pad_enh), '0);
        do_write(6'd12, 12'h5A5, 1'b0);
        apply_req = 1'b1;
        tick();
        apply_req = 1'b0;
        repeat (5) tick();
        check("pend_busy", PW'(apply_busy), PW'(1));
        check("pend_no_hold", PW'(pad_hold_n), PW'({NP{1'b1}}));
        check("pend_no_done", PW'(apply_done), '0);
        check("pend_ready", PW'(cfg_ready), PW'(1));
        porb = 1'b1;
        watch(12, 20, -1, -1, hc, hf, ck, dc, dk, ob, rs);
        check("pend_hold_cycles", PW'(hc), PW'(2*HC+1));
        check("pend_done_count", PW'(dc), PW'(1));
        model_apply();
        push("pend_pad_cfg", model_vec());
        pop_check(pad_cfg);

        do_write(6'd20, 12'h777, 1'b0);
        apply_req = 1'b1;
        tick();
        apply_req = 1'b0;
        watch(20, HC + 3, -1, -1, hc, hf, ck, dc, dk, ob, rs);
        check("midrst_hold_before", PW'(pad_hold_n[20]), '0);
        check("midrst_cfg_before", PW'(pad_cfg[12*20 +: 12]), PW'(12'h777));
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        check("midrst_hold_release", PW'(pad_hold_n), PW'({NP{1'b1}}));
        check("midrst_cfg_reset", pad_cfg, model_vec());
        check("midrst_busy", PW'(apply_busy), '0);
        @(negedge clock);
        resetb = 1'b1;
        tick();
        check("midrst_ready_back", PW'(cfg_ready), PW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
